// File: rtl/multiplier_seq_control_pkg.sv
// Shared types for the sequential multiplier.
// State encoding and step bounds.
package multiplier_seq_control_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LAST = 2'd3;

endpackage

// File: rtl/multiplier_seq_control_mult.sv
// Combinational unsigned W x W multiplier.
// Shared by the sequencer one half-product per cycle.
module multiplier_C #(
  parameter int W = 12
) (
  input  logic [W-1:0]   Data_A_i,
  input  logic [W-1:0]   Data_B_i,
  output logic [2*W-1:0] Data_S_o
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;

  assign a_ext = {{W{1'b0}}, Data_A_i};
  assign b_ext = {{W{1'b0}}, Data_B_i};

  assign Data_S_o = a_ext * b_ext;

endmodule

// File: rtl/multiplier_seq_control.sv
// Four-cycle W x W multiplier built on one
// shared (W/2) x (W/2) combinational multiplier.
module multiplier_seq_control
  import multiplier_seq_control_pkg::*;
#(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   Data_A_i,
  input  logic [W-1:0]   Data_B_i,
  output logic           busy_o,
  output logic           ready_o,
  output logic [2*W-1:0] Data_S_o
);

  localparam int H = W / 2;

  state_t         state;
  state_t         state_d;
  logic [1:0]     step;
  logic [2*W-1:0] acc;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [H-1:0]   mul_a;
  logic [H-1:0]   mul_b;
  logic [W-1:0]   pp;
  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] pp_sh;
  logic [2*W-1:0] sum;
  logic           accept;

  assign accept = start_i &&
                  (state == IDLE || state == DONE);
  assign busy_o = (state == MUL);

  // Select half operands and weight of this step's partial product.
  always_comb begin
    mul_a = a_q[H-1:0];
    mul_b = b_q[H-1:0];
    pp_sh = pp_ext;
    unique case (step)
      2'd0: begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[H-1:0];
        pp_sh = pp_ext;
      end
      2'd1: begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[W-1:H];
        pp_sh = pp_ext << H;
      end
      2'd2: begin
        mul_a = a_q[W-1:H];
        mul_b = b_q[H-1:0];
        pp_sh = pp_ext << H;
      end
      2'd3: begin
        mul_a = a_q[W-1:H];
        mul_b = b_q[W-1:H];
        pp_sh = pp_ext << (2 * H);
      end
    endcase
  end

  multiplier_C #(
    .W(H)
  ) u_mul (
    .Data_A_i(mul_a),
    .Data_B_i(mul_b),
    .Data_S_o(pp)
  );

  assign pp_ext = {{W{1'b0}}, pp};
  assign sum    = acc + pp_sh;

  // Next-state logic of the sequencer.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start_i) state_d = MUL;
      MUL:  if (step == STEP_LAST) state_d = DONE;
      DONE: state_d = start_i ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step     <= 2'd0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ready_o  <= 1'b0;
      Data_S_o <= '0;
    end else begin
      ready_o <= 1'b0;
      if (accept) begin
        a_q  <= Data_A_i;
        b_q  <= Data_B_i;
        acc  <= '0;
        step <= 2'd0;
      end else if (state == MUL) begin
        acc  <= sum;
        step <= step + 2'd1;
        if (step == STEP_LAST) begin
          Data_S_o <= sum;
          ready_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplier_seq_control.sv
// Directed bench for the sequential multiplier.
// Covers W=24 vectors and an exhaustive W=4 sweep.
module tb_multiplier_seq_control;

  logic        clk;
  logic        rst;

  logic        start24;
  logic [23:0] a24;
  logic [23:0] b24;
  logic        busy24;
  logic        ready24;
  logic [47:0] s24;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        ready4;
  logic [7:0]  s4;

  int errors;
  int checks;

  multiplier_seq_control #(.W(24)) dut24 (
    .clk(clk),
    .rst(rst),
    .start_i(start24),
    .Data_A_i(a24),
    .Data_B_i(b24),
    .busy_o(busy24),
    .ready_o(ready24),
    .Data_S_o(s24)
  );

  multiplier_seq_control #(.W(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .start_i(start4),
    .Data_A_i(a4),
    .Data_B_i(b4),
    .busy_o(busy4),
    .ready_o(ready4),
    .Data_S_o(s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic op24(input logic [23:0] a,
                      input logic [23:0] b,
                      input logic [47:0] exp,
                      input string tag);
    @(negedge clk);
    a24 = a;
    b24 = b;
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    a24 = 24'h5A5A5A;
    b24 = 24'hA5A5A5;
    chk({tag, " busy t"}, 64'(busy24), 64'd1);
    chk({tag, " rdy t"}, 64'(ready24), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, " busy mul"}, 64'(busy24), 64'd1);
      chk({tag, " rdy mul"}, 64'(ready24), 64'd0);
    end
    @(negedge clk);
    chk({tag, " busy done"}, 64'(busy24), 64'd0);
    chk({tag, " rdy done"}, 64'(ready24), 64'd1);
    chk({tag, " prod"}, 64'(s24), 64'(exp));
    @(negedge clk);
    chk({tag, " rdy after"}, 64'(ready24), 64'd0);
    chk({tag, " hold"}, 64'(s24), 64'(exp));
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    start24 = 1'b0;
    a24     = '0;
    b24     = '0;
    start4  = 1'b0;
    a4      = '0;
    b4      = '0;

    repeat (2) @(negedge clk);
    chk("rst busy", 64'(busy24), 64'd0);
    chk("rst rdy", 64'(ready24), 64'd0);
    chk("rst prod", 64'(s24), 64'd0);
    chk("rst prod4", 64'(s4), 64'd0);
    rst = 1'b0;

    op24(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max");
    op24(24'h800000, 24'h000002, 48'h000001000000, "msb");
    op24(24'h000000, 24'hABCDEF, 48'h0, "zero");

    // start held high across a whole operation
    @(negedge clk);
    a24 = 24'd3;
    b24 = 24'd5;
    start24 = 1'b1;
    @(negedge clk);
    a24 = 24'd7;
    b24 = 24'd9;
    chk("held busy", 64'(busy24), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("held busy mul", 64'(busy24), 64'd1);
      chk("held rdy mul", 64'(ready24), 64'd0);
    end
    @(negedge clk);
    chk("held rdy1", 64'(ready24), 64'd1);
    chk("held prod1", 64'(s24), 64'd15);
    @(negedge clk);
    start24 = 1'b0;
    chk("b2b busy", 64'(busy24), 64'd1);
    chk("b2b rdy", 64'(ready24), 64'd0);
    chk("b2b hold", 64'(s24), 64'd15);
    repeat (3) begin
      @(negedge clk);
      chk("b2b rdy low", 64'(ready24), 64'd0);
    end
    @(negedge clk);
    chk("held rdy2", 64'(ready24), 64'd1);
    chk("held prod2", 64'(s24), 64'd63);
    @(negedge clk);
    chk("held idle", 64'(ready24), 64'd0);

    // reset during step 2
    @(negedge clk);
    a24 = 24'hFFFFFF;
    b24 = 24'hFFFFFF;
    start24 = 1'b1;
    @(negedge clk);
    start24 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst prod", 64'(s24), 64'd0);
    chk("mid rst busy", 64'(busy24), 64'd0);
    chk("mid rst rdy", 64'(ready24), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post rst rdy", 64'(ready24), 64'd0);
      chk("post rst prod", 64'(s24), 64'd0);
    end
    op24(24'd2, 24'd3, 48'd6, "after rst");

    // exhaustive W=4 sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ref_p;
      ref_p = 8'(i[7:4]) * 8'(i[3:0]);
      @(negedge clk);
      a4 = i[7:4];
      b4 = i[3:0];
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~a4;
      b4 = ~b4;
      repeat (3) @(negedge clk);
      chk("w4 early", 64'(ready4), 64'd0);
      @(negedge clk);
      chk("w4 rdy", 64'(ready4), 64'd1);
      chk("w4 prod", 64'(s4), 64'(ref_p));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
